spi_master: RTL and testbench

- Host-side SPI master that drives the spiMemory slave's sclk/cs/mosi pins and captures miso.
- Accepts one read or write request at a time through a start/busy/done handshake.
- Serialises a 16-bit frame: address byte {addr[6:0], rw}, then one data byte.
- Sits directly upstream of the slave, either on the FPGA test harness or on the host board.

---
 rtl/spi_pkg.sv | 26 ++
 rtl/spi_clkgen.sv | 39 +++
 rtl/spi_master.sv | 160 ++++++++++++++++
 tb/tb_spi_master.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Frame constants and FSM state encoding shared by the SPI master and the spiMemory slave.
package spi_pkg;

  localparam int   ADDR_W     = 7;
  localparam int   DATA_W     = 8;
  localparam int   FRAME_BITS = ADDR_W + 1 + DATA_W;
  localparam logic RW_READ    = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } spi_state_t;

  // Read frames carry zeros in the data byte; the slave drives the data instead.
  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic [ADDR_W-1:0] addr,
    input logic              rw,
    input logic [DATA_W-1:0] wdata
  );
    return {addr, rw, (rw == RW_READ) ? {DATA_W{1'b0}} : wdata};
  endfunction

endpackage

// File: rtl/spi_clkgen.sv
// SCLK generator: divides clk by 2*CLK_DIV while enabled and flags the clk cycle
// in which sclk is driven high (rise) or low (fall). Idles low when disabled.
module spi_clkgen #(
  parameter int CLK_DIV = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int              DIV_W    = $clog2(CLK_DIV) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] divcnt;
  logic             wrap;

  assign wrap = en && (divcnt == DIV_LAST);
  assign rise = wrap && !sclk;
  assign fall = wrap && sclk;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      divcnt <= '0;
      sclk   <= 1'b0;
    end else if (!en) begin
      divcnt <= '0;
      sclk   <= 1'b0;
    end else if (wrap) begin
      divcnt <= '0;
      sclk   <= !sclk;
    end else begin
      divcnt <= divcnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI master issuing one 16-bit {addr, rw, data} frame per start request.
// Define SPI_MASTER_LOOPBACK_EN to add a loopback input that captures mosi instead of miso.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV  = 8,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4,
  parameter int CS_GAP   = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              cs_n,
  output logic              mosi,
`ifdef SPI_MASTER_LOOPBACK_EN
  input  logic              loopback,
`endif
  input  logic              miso
);

  localparam int SETUP_W = $clog2(CS_SETUP) + 1;
  localparam int HOLD_W  = $clog2(CS_HOLD) + 1;
  localparam int GAP_W   = $clog2(CS_GAP) + 1;

  localparam logic [SETUP_W-1:0] SETUP_LAST     = SETUP_W'(CS_SETUP);
  localparam logic [HOLD_W-1:0]  HOLD_LAST      = HOLD_W'(CS_HOLD - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST       = GAP_W'(CS_GAP - 1);
  localparam logic [3:0]         FIRST_DATA_BIT = 4'(ADDR_W + 1);
  localparam logic [3:0]         LAST_BIT       = 4'(FRAME_BITS - 1);

  spi_state_t              state;
  logic [FRAME_BITS-1:0]   shreg;
  logic [FRAME_BITS-1:0]   frame_in;
  logic                    rw_lat;
  logic [3:0]              bitcnt;
  logic [DATA_W-1:0]       rdata_sh;
  logic [SETUP_W-1:0]      setup_cnt;
  logic [HOLD_W-1:0]       hold_cnt;
  logic [GAP_W-1:0]        gap_cnt;
  logic                    sclk_en;
  logic                    rise;
  logic                    fall;
  logic                    cap_bit;

  assign frame_in = build_frame(addr, rw, wdata);
  assign sclk_en  = (state == SHIFT);

`ifdef SPI_MASTER_LOOPBACK_EN
  assign cap_bit = loopback ? mosi : miso;
`else
  assign cap_bit = miso;
`endif

  spi_clkgen #(
    .CLK_DIV(CLK_DIV)
  ) u_clkgen (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (sclk_en),
    .sclk   (sclk),
    .rise   (rise),
    .fall   (fall)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      shreg     <= '0;
      rw_lat    <= 1'b0;
      bitcnt    <= '0;
      rdata_sh  <= '0;
      rdata     <= '0;
      setup_cnt <= '0;
      hold_cnt  <= '0;
      gap_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cs_n      <= 1'b1;
      mosi      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg     <= frame_in;
            rw_lat    <= rw;
            bitcnt    <= '0;
            rdata_sh  <= '0;
            setup_cnt <= '0;
            busy      <= 1'b1;
            cs_n      <= 1'b0;
            mosi      <= frame_in[FRAME_BITS-1];
            state     <= SETUP;
          end
        end

        SETUP: begin
          if (setup_cnt == SETUP_LAST) begin
            state <= SHIFT;
          end else begin
            setup_cnt <= setup_cnt + SETUP_W'(1);
          end
        end

        SHIFT: begin
          // miso is only looked at on read data bits, so a floating line elsewhere is harmless.
          if (rise && (bitcnt >= FIRST_DATA_BIT) && (rw_lat == RW_READ)) begin
            rdata_sh <= {rdata_sh[DATA_W-2:0], cap_bit};
          end
          if (fall) begin
            bitcnt <= bitcnt + 4'd1;
            if (bitcnt == LAST_BIT) begin
              hold_cnt <= '0;
              state    <= HOLD;
            end else begin
              shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
              mosi  <= shreg[FRAME_BITS-2];
            end
          end
        end

        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            cs_n    <= 1'b1;
            mosi    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            gap_cnt <= '0;
            if (rw_lat == RW_READ) begin
              rdata <= rdata_sh;
            end
            state <= GAP;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end

        GAP: begin
          // start is deliberately ignored here; cs_n must stay high for the full gap.
          if (gap_cnt == GAP_LAST) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master with a behavioural spiMemory slave and a byte-level reference model.
module tb_spi_master;
  import spi_pkg::*;

  localparam int CLK_DIV   = 8;
  localparam int CS_SETUP  = 4;
  localparam int CS_HOLD   = 4;
  localparam int CS_GAP    = 8;
  localparam int FRAME_CYC = 1 + CS_SETUP + 32 * CLK_DIV + CS_HOLD;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] addr = '0;
  logic [7:0] wdata = '0;
  logic [7:0] rdata;
  logic       busy, done, sclk, cs_n, mosi, miso;
`ifdef SPI_MASTER_LOOPBACK_EN
  logic       loopback = 1'b0;
`endif

  always #5 clk = ~clk;

  spi_master #(
    .CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_GAP(CS_GAP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
    .rdata(rdata), .busy(busy), .done(done), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
`ifdef SPI_MASTER_LOOPBACK_EN
    .loopback(loopback),
`endif
    .miso(miso)
  );

  // Behavioural slave: samples mosi on sclk rise, drives read data on sclk fall.
  logic [7:0]  smem [128];
  int          sbits = 0;
  logic [15:0] sin = '0;
  logic        sread = 1'b0;
  logic [7:0]  rbyte = '0;
  logic        miso_drv = 1'bz;
  assign miso = miso_drv;

  always @(posedge sclk or posedge cs_n) begin
    if (cs_n) begin
      sbits = 0;
      sread = 1'b0;
    end else begin
      sin = {sin[14:0], mosi};
      sbits++;
      if (sbits == 8) begin
        sread = sin[0];
        rbyte = smem[sin[7:1]];
      end
      if (sbits == 16 && !sread) smem[sin[15:9]] = sin[7:0];
    end
  end

  always @(negedge sclk or posedge cs_n) begin
    if (cs_n) miso_drv = 1'bz;
    else if (sread && sbits >= 8 && sbits < 16) miso_drv = rbyte[3'(15 - sbits)];
    else miso_drv = 1'bz;
  end

  // Pin monitors
  int          cs_low_run = 0, cs_low_last = 0, cs_high_run = 0, cs_high_last = 0, done_cnt = 0;
  int          rise_cnt = 0;
  logic [15:0] mosi_cap = '0;

  always @(negedge clk) begin
    if (cs_n === 1'b0) begin
      cs_low_run++;
      if (cs_high_run != 0) begin cs_high_last = cs_high_run; cs_high_run = 0; end
    end else begin
      cs_high_run++;
      if (cs_low_run != 0) begin cs_low_last = cs_low_run; cs_low_run = 0; end
    end
    if (done === 1'b1) done_cnt++;
  end

  always @(posedge sclk) begin
    mosi_cap = {mosi_cap[14:0], mosi};
    rise_cnt++;
  end

  // Reference model: the memory as bytes plus the last read result.
  logic [7:0] ref_mem [128];
  logic [7:0] ref_last = 8'h00;

  int errors = 0, checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic wait_level(input int sel, input int tgt, input string name);
    bit hit = 1'b0;
    for (int n = 0; n < FRAME_CYC + CS_GAP + 40; n++) begin
      @(negedge clk);
      if ((sel == 0 && busy === 1'b1) || (sel == 1 && done === 1'b1) ||
          (sel == 2 && rise_cnt >= tgt)) begin
        hit = 1'b1;
        break;
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL %s: timed out waiting, got no event, expected event", name);
    end
  endtask

  logic [15:0] f_cap;
  logic [7:0]  f_rd;
  int          f_low, f_dones, f_rises;
  logic        f_busy, f_busy_done;

  task automatic run_frame(input logic r, input logic [6:0] a, input logic [7:0] d);
    int d0, r0;
    @(negedge clk);
    d0 = done_cnt;
    r0 = rise_cnt;
    rw = r; addr = a; wdata = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    f_busy = busy;
    rw = 1'($urandom); addr = 7'($urandom); wdata = 8'($urandom);
    wait_level(1, 0, "frame.done");
    f_rd = rdata;
    f_busy_done = busy;
    f_cap = mosi_cap;
    repeat (2) @(negedge clk);
    f_low = cs_low_last;
    f_dones = done_cnt - d0;
    f_rises = rise_cnt - r0;
    repeat (CS_GAP) @(negedge clk);
  endtask

  task automatic do_and_check(input string tag, input logic r, input logic [6:0] a,
                              input logic [7:0] d, input logic [15:0] ef, input logic [7:0] er);
    run_frame(r, a, d);
    check({tag, ".mosi"}, 32'(f_cap), 32'(ef));
    check({tag, ".rdata"}, 32'(f_rd), 32'(er));
    check({tag, ".cs_low"}, 32'(f_low), 32'(FRAME_CYC));
    check({tag, ".done_pulses"}, 32'(f_dones), 32'd1);
    check({tag, ".rises"}, 32'(f_rises), 32'd16);
    check({tag, ".busy"}, {31'd0, f_busy}, 32'd1);
    check({tag, ".busy_at_done"}, {31'd0, f_busy_done}, 32'd0);
    $display("txn %s rw=%0d addr=%02h wdata=%02h mosi=%04h rdata=%02h", tag, r, a, d, f_cap, f_rd);
  endtask

  // Reference model step: expected frame and rdata, then state update.
  task automatic model_txn(input string tag, input logic r, input logic [6:0] a, input logic [7:0] d);
    logic [15:0] ef;
    logic [7:0]  er;
    ef = {a, r, (r ? 8'h00 : d)};
    er = r ? ref_mem[a] : ref_last;
    do_and_check(tag, r, a, d, ef, er);
    if (r) ref_last = ref_mem[a];
    else   ref_mem[a] = d;
  endtask

  typedef struct packed {
    logic       r;
    logic [6:0] a;
    logic [7:0] d;
    logic [15:0] ef;
    logic [7:0] er;
  } vec_t;

  vec_t vt [7];

  initial begin
    #(800_000);
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, r0;
    logic [6:0] a1, a2;
    logic [7:0] d1, d2, v;

    vt[0] = '{1'b0, 7'h2A, 8'hC5, 16'h54C5, 8'h00};
    vt[1] = '{1'b0, 7'h10, 8'hA5, 16'h20A5, 8'h00};
    vt[2] = '{1'b1, 7'h10, 8'hFF, 16'h2100, 8'hA5};
    vt[3] = '{1'b0, 7'h11, 8'h5A, 16'h225A, 8'hA5};
    vt[4] = '{1'b1, 7'h11, 8'h00, 16'h2300, 8'h5A};
    vt[5] = '{1'b0, 7'h2A, 8'h3C, 16'h543C, 8'h5A};
    vt[6] = '{1'b1, 7'h2A, 8'h81, 16'h5500, 8'h3C};

    #2 reset_n = 1'b0;
    #1;
    check("reset.sclk",  {31'd0, sclk},  32'd0);
    check("reset.cs_n",  {31'd0, cs_n},  32'd1);
    check("reset.mosi",  {31'd0, mosi},  32'd0);
    check("reset.busy",  {31'd0, busy},  32'd0);
    check("reset.done",  {31'd0, done},  32'd0);
    check("reset.rdata", 32'(rdata), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      do_and_check($sformatf("vec%0d", i), vt[i].r, vt[i].a, vt[i].d, vt[i].ef, vt[i].er);
      if (vt[i].r) ref_last = ref_mem[vt[i].a];
      else         ref_mem[vt[i].a] = vt[i].d;
    end

    // Seed the small random address window so every later read has a known value.
    for (int i = 0; i < 8; i++) begin
      v = 8'($urandom);
      model_txn($sformatf("seed%0d", i), 1'b0, 7'(i), v);
    end
    for (int i = 0; i < 20; i++) begin
      model_txn($sformatf("rnd%0d", i), 1'($urandom), 7'($urandom_range(0, 7)), 8'($urandom));
    end

    // Back-to-back with start held high; inputs change while busy.
    a1 = 7'h05; d1 = 8'h6E; a2 = 7'h06; d2 = 8'h19;
    @(negedge clk);
    d0 = done_cnt;
    rw = 1'b0; addr = a1; wdata = d1; start = 1'b1;
    wait_level(0, 0, "b2b.busy1");
    addr = a2; wdata = d2;
    wait_level(1, 0, "b2b.done1");
    check("b2b.frame1", 32'(mosi_cap), 32'({a1, 1'b0, d1}));
    wait_level(0, 0, "b2b.busy2");
    start = 1'b0; addr = 7'h7F; wdata = 8'hFF;
    @(negedge clk);
    checks++;
    if (cs_high_last < CS_GAP || cs_high_last > CS_GAP + 2) begin
      errors++;
      $display("FAIL b2b.gap: got %0d high cycles, expected %0d..%0d", cs_high_last, CS_GAP, CS_GAP + 2);
    end
    wait_level(1, 0, "b2b.done2");
    check("b2b.frame2", 32'(mosi_cap), 32'({a2, 1'b0, d2}));
    repeat (CS_GAP + 4) @(negedge clk);
    check("b2b.done_pulses", 32'(done_cnt - d0), 32'd2);
    $display("txn b2b frame1=%02h/%02h frame2=%02h/%02h gap=%0d", a1, d1, a2, d2, cs_high_last);
    ref_mem[a1] = d1;
    ref_mem[a2] = d2;
    model_txn("b2b.readback", 1'b1, a1, 8'h00);

    // Reset in the middle of bit 5 of a write frame.
    @(negedge clk);
    d0 = done_cnt;
    r0 = rise_cnt;
    rw = 1'b0; addr = 7'h33; wdata = 8'h77; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_level(2, r0 + 5, "rst.bit5");
    #2 reset_n = 1'b0;
    #1;
    check("rst.sclk",  {31'd0, sclk}, 32'd0);
    check("rst.cs_n",  {31'd0, cs_n}, 32'd1);
    check("rst.busy",  {31'd0, busy}, 32'd0);
    check("rst.done",  {31'd0, done}, 32'd0);
    check("rst.rdata", 32'(rdata), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (FRAME_CYC) @(negedge clk);
    check("rst.no_done", 32'(done_cnt - d0), 32'd0);
    $display("txn reset_abort addr=33 wdata=77 rises_before_reset=%0d", rise_cnt - r0);
    ref_last = 8'h00;
    model_txn("post_rst", 1'b0, 7'h34, 8'h9C);
    model_txn("post_rst.read", 1'b1, 7'h34, 8'h00);

`ifdef SPI_MASTER_LOOPBACK_EN
    model_txn("lb.prep", 1'b0, 7'h00, 8'hFF);
    model_txn("lb.prep_read", 1'b1, 7'h00, 8'h00);
    loopback = 1'b1;
    do_and_check("lb.read", 1'b1, 7'h00, 8'h00, 16'h0100, 8'h00);
    do_and_check("lb.write", 1'b0, 7'h00, 8'h96, 16'h0096, 8'h00);
    loopback = 1'b0;
    ref_last = 8'h00;
    ref_mem[0] = 8'h96;
    model_txn("lb.after", 1'b1, 7'h00, 8'h00);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
